chan_output_framer: RTL and testbench

Output framing stage of the channelizer, placed directly downstream of the I and Q `dsp48_output_add` output adders. It re-aligns the input valid strobe with the adders' fixed pipeline latency and captures each halved 16-bit I/Q sum. It tags every sample with its channel index and buffers the samples in a small FIFO. It presents them on a valid/ready stream with an end-of-frame marker on the last channel.

---
 rtl/chan_output_framer_pkg.sv | 12 +
 rtl/chan_sync_fifo.sv | 57 +++++
 rtl/chan_output_framer.sv | 64 ++++++
 tb/tb_chan_output_framer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/chan_output_framer_pkg.sv
// chan_output_framer_pkg: shared channelizer constants and the tagged sample layout.
package chan_output_framer_pkg;
  localparam int NUM_CHANNELS_DEF = 64;
  localparam int CHAN_W = $clog2(NUM_CHANNELS_DEF);
  // Must track the dsp48_output_add pipeline register settings (AREG/DREG, ADREG, PREG).
  localparam int ADD_LATENCY_DEF = 3;
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [15:0]       q;
    logic [15:0]       i;
  } sample_t;
endpackage

// File: rtl/chan_sync_fifo.sv
// chan_sync_fifo: first-word-fall-through FIFO whose head sits in a registered output stage.
module chan_sync_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] out_q, out_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ov_q, ov_d, rd, acc, load, buf_empty, pop, direct, push;
  // cnt_q counts the output register too, so a full FIFO holds DEPTH-1 words in mem_q.
  always_comb begin
    full_o = cnt_q[AW];
    empty_o = cnt_q == '0;
    rd = ov_q && rd_en_i;
    acc = wr_en_i && (!full_o || rd);
    load = !ov_q || rd;
    buf_empty = cnt_q == {{AW{1'b0}}, ov_q};
    pop = load && !buf_empty;
    direct = load && buf_empty && acc;
    push = acc && !direct;
    wp_d = push ? wp_q + {{(AW-1){1'b0}}, 1'b1} : wp_q;
    rp_d = pop ? rp_q + {{(AW-1){1'b0}}, 1'b1} : rp_q;
    cnt_d = cnt_q + {{AW{1'b0}}, acc} - {{AW{1'b0}}, rd};
    ov_d = load ? (pop || direct) : ov_q;
    out_d = pop ? mem_q[rp_q] : direct ? wr_data_i : out_q;
    rd_data_o = out_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
      out_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      out_q <= out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data_i;
  end
endmodule

// File: rtl/chan_output_framer.sv
// chan_output_framer: aligns adder valid, tags I/Q sums with a channel index and streams them out.
module chan_output_framer
  import chan_output_framer_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int ADD_LATENCY  = ADD_LATENCY_DEF,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            in_valid,
  input  logic [15:0]                     sum_i,
  input  logic [15:0]                     sum_q,
  output logic [31:0]                     out_data,
  output logic [$clog2(NUM_CHANNELS)-1:0] out_chan,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow,
  input  logic                            overflow_clr
);
  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int W = CW + 32;
  logic [ADD_LATENCY-1:0] dl_q, dl_d;
  logic [CW-1:0] chan_q, chan_d;
  logic ovf_q, ovf_d, cap_valid, full, empty, rd, drop;
  logic [W-1:0] rd_data;
  // Counter wraps for free since NUM_CHANNELS is a power of two; dropped samples still advance it.
  always_comb begin
    dl_d = dl_q << 1;
    dl_d[0] = in_valid;
    cap_valid = dl_q[ADD_LATENCY-1];
    rd = out_valid && out_ready;
    drop = cap_valid && full && !rd;
    chan_d = cap_valid ? chan_q + {{(CW-1){1'b0}}, 1'b1} : chan_q;
    ovf_d = drop || (ovf_q && !overflow_clr);
    out_valid = !empty;
    out_data = rd_data[31:0];
    out_chan = rd_data[W-1:32];
    out_last = &out_chan;
    overflow = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dl_q <= '0;
      chan_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dl_q <= dl_d;
      chan_q <= chan_d;
      ovf_q <= ovf_d;
    end
  end
  chan_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (cap_valid),
    .wr_data_i ({chan_q, sum_q, sum_i}),
    .rd_en_i   (out_ready),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );
endmodule

// File: tb/tb_chan_output_framer.sv
// tb_chan_output_framer: directed and randomized stimulus checked against a queue-based model.
`timescale 1ns/1ps
module tb_chan_output_framer;
  import chan_output_framer_pkg::*;
  localparam int N = 64, L = 3, D = 16;
  logic clk = 0, resetn = 0, in_valid = 0, out_ready = 0, overflow_clr = 0;
  logic [15:0] sum_i = 0, sum_q = 0;
  logic [31:0] out_data;
  logic [5:0] out_chan;
  logic out_last, out_valid, overflow;
  int checks = 0, errors = 0;
  sample_t mq[$];
  int mchan = 0;
  bit mov = 0, chk_en = 0;
  bit hist[L];
  int seen[$];
  int lasts = 0;
  logic [31:0] hold;

  always #5 clk = ~clk;

  chan_output_framer #(.NUM_CHANNELS(N), .ADD_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .sum_i(sum_i), .sum_q(sum_q),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic int seen_at(input int k);
    return seen.size() > k ? seen[k] : -1;
  endfunction

  task automatic step(input bit v, input bit rdy, input bit clr = 0, input bit rst = 0,
                      input int si = -1, input int sq = -1);
    @(posedge clk);
    #1;
    in_valid = v;
    out_ready = rdy;
    overflow_clr = clr;
    resetn = !rst;
    sum_i = si >= 0 ? 16'(si) : 16'($urandom);
    sum_q = sq >= 0 ? 16'(sq) : 16'($urandom);
    @(negedge clk);
    if (out_valid && out_ready) begin
      seen.push_back(int'(out_chan));
      lasts += int'(out_last);
    end
  endtask

  // Reference: samples captured ADD_LATENCY cycles after in_valid, queue of at most D words.
  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      mchan = 0;
      mov = 0;
      foreach (hist[k]) hist[k] = 0;
    end else begin
      bit cap, rdm, drop;
      sample_t s;
      drop = 0;
      rdm = mq.size() > 0 && out_ready;
      cap = hist[L-1];
      for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_valid;
      if (rdm) void'(mq.pop_front());
      if (cap) begin
        s.chan = 6'(mchan);
        s.q = sum_q;
        s.i = sum_i;
        if (mq.size() < D) mq.push_back(s);
        else drop = 1;
        mchan = (mchan + 1) % N;
      end
      if (drop) mov = 1;
      else if (overflow_clr) mov = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", out_valid, mq.size() > 0);
      chk("overflow", overflow, mov);
      if (out_valid && mq.size() > 0) begin
        chk("data", out_data, {mq[0].q, mq[0].i});
        chk("chan", out_chan, mq[0].chan);
        chk("last", out_last, mq[0].chan == 6'(N - 1));
      end
    end
  end

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_en = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    // Latency
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1, 0, 0, 'h1234, 'hFFFE);
    chk("lat_no_bypass", out_valid, 0);
    step(0, 1);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'hFFFE1234);
    chk("lat_chan", out_chan, 0);
    chk("lat_last", out_last, 0);
    // Frame
    step(0, 1, 0, 1);
    seen.delete();
    lasts = 0;
    for (int k = 0; k < 65; k++) step(1, 1);
    for (int k = 0; k < L + 2; k++) step(0, 1);
    begin
      int bad = 0;
      foreach (seen[k]) if (seen[k] != k % N) bad++;
      chk("frame_count", seen.size(), 65);
      chk("frame_seq_bad", bad, 0);
      chk("frame_chan63", seen_at(63), 63);
      chk("frame_chan64", seen_at(64), 0);
      chk("frame_lasts", lasts, 1);
    end
    // Backpressure
    step(0, 0, 0, 1);
    seen.delete();
    for (int k = 0; k < 20; k++) step(1, 0);
    for (int k = 0; k < L + 1; k++) step(0, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_chan", out_chan, 0);
    chk("bp_overflow", overflow, 1);
    hold = out_data;
    for (int k = 0; k < 3; k++) step(0, 0);
    chk("bp_stable", out_data, hold);
    for (int k = 0; k < D; k++) step(0, 1);
    step(1, 1);
    for (int k = 0; k < L + 2; k++) step(0, 1);
    chk("bp_count", seen.size(), 17);
    chk("bp_first", seen_at(0), 0);
    chk("bp_16th", seen_at(15), 15);
    chk("bp_after_gap", seen_at(16), 20);
    // Refill, clear without drop, full-with-read, clear with drop
    seen.delete();
    for (int k = 0; k < D; k++) step(1, 0);
    for (int k = 0; k < L + 1; k++) step(0, 0);
    step(0, 0, 1);
    step(0, 0);
    chk("clr_nodrop", overflow, 0);
    step(1, 0);
    for (int k = 0; k < L - 1; k++) step(0, 0);
    step(0, 1);
    step(0, 0);
    chk("fullrd_overflow", overflow, 0);
    chk("fullrd_head", out_chan, 22);
    step(1, 0);
    for (int k = 0; k < L - 1; k++) step(0, 0);
    step(0, 0, 1);
    step(0, 0);
    chk("clr_with_drop", overflow, 1);
    seen.delete();
    for (int k = 0; k < 20; k++) step(0, 1);
    chk("fullrd_count", seen.size(), 16);
    chk("fullrd_first", seen_at(0), 22);
    chk("fullrd_last", seen_at(15), 37);
    // Reset mid-frame with 5 queued at chan_cnt 37
    step(0, 1, 0, 1);
    for (int k = 0; k < 32; k++) step(1, 1);
    for (int k = 0; k < L + 2; k++) step(0, 1);
    for (int k = 0; k < 5; k++) step(1, 0);
    for (int k = 0; k < L + 1; k++) step(0, 0);
    chk("mid_head", out_chan, 32);
    step(1, 0);
    step(1, 0);
    step(0, 0, 0, 1);
    step(0, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_chan", out_chan, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_overflow", overflow, 0);
    seen.delete();
    for (int k = 0; k < L + 2; k++) step(0, 1);
    chk("mid_inflight", seen.size(), 0);
    step(1, 1);
    for (int k = 0; k < L + 2; k++) step(0, 1);
    chk("mid_first_chan", seen_at(0), 0);
    // Random
    for (int k = 0; k < 4000; k++) begin
      bit rdy;
      rdy = ((k / 200) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      step($urandom_range(0, 9) < 7, rdy, $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
